// File: rtl/sim_finisher_mc.sv
// sim_finisher_mc: clocked multi-channel simulation finisher.
// Watches NCH report channels, logs every value change through a FIFO with a
// valid/ready drain port, filters done/success, runs an optional cycle
// watchdog and only declares the end of simulation once every pending report
// has been drained.
module sim_finisher_mc #(
    parameter int NCH       = 4,
    parameter int W         = 32,
    parameter int DEPTH     = 8,
    parameter int DONE_HOLD = 2,
    parameter int TIMEOUT   = 0,
    parameter int FINISH_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH*W-1:0] report,
    input  logic             success,
    input  logic             done,
    input  logic             log_ready,
    output logic             log_valid,
    output logic [3:0]       log_chan,
    output logic [W-1:0]     log_data,
    output logic [15:0]      coalesced,
    output logic [31:0]      cycle_count,
    output logic             finished,
    output logic             passed,
    output logic             timed_out
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [15:0] HOLD_MAX = 16'(DONE_HOLD);
    localparam logic [15:0] HOLD_M1  = 16'(DONE_HOLD - 1);
    // The watchdog fires on the cycle whose edge takes cycle_count to TIMEOUT.
    localparam logic [31:0] TO_M1    = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_FIN   = 2'd2;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [4:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {12'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] a);
        return (a == 32'hFFFF_FFFF) ? a : a + 32'd1;
    endfunction

    // Detect stage (p0 = combinational compare, p1 = shadow/pending registers)
    logic [W-1:0]   shadow_p1 [NCH];
    logic [NCH-1:0] pend_p1;
    logic [NCH-1:0] chg_p0;
    logic [NCH-1:0] pop_ch;

    // Push stage (p2 = FIFO)
    logic           any_pend;
    logic           push;
    logic           pop;
    logic [3:0]     sel;
    logic [W-1:0]   push_data;
    logic [4:0]     coal_inc;
    logic [3:0]     chan_mem [DEPTH];
    logic [W-1:0]   data_mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    fifo_cnt;

    // Control
    logic [15:0]    hold_cnt;
    logic           accept;
    logic           wd_fire;
    logic           drain_idle;
    logic           succ_cap;
    logic [1:0]     state;

    // A channel has changed when its input differs from the last recorded value.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            chg_p0[c] = (report[c*W +: W] != shadow_p1[c]);
        end
    end

    // Fixed-priority pick of the lowest pending channel and coalesce accounting.
    always_comb begin
        any_pend  = 1'b0;
        sel       = 4'd0;
        push_data = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (pend_p1[c]) begin
                any_pend  = 1'b1;
                sel       = 4'(c);
                push_data = shadow_p1[c];
            end
        end
        push = any_pend && (fifo_cnt != FULL_CNT);
        for (int c = 0; c < NCH; c++) begin
            pop_ch[c] = push && (sel == 4'(c));
        end
        // A change on a channel whose previous value is still waiting (and is
        // not leaving this cycle) overwrites that value.
        coal_inc = 5'd0;
        for (int c = 0; c < NCH; c++) begin
            coal_inc = coal_inc + {4'd0, chg_p0[c] & pend_p1[c] & ~pop_ch[c]};
        end
    end

    assign pop       = log_valid && log_ready;
    assign log_valid = (fifo_cnt != '0);
    assign log_chan  = log_valid ? chan_mem[rd_ptr] : 4'd0;
    assign log_data  = log_valid ? data_mem[rd_ptr] : '0;

    assign accept     = (state == ST_RUN) && done && (hold_cnt >= HOLD_M1);
    assign wd_fire    = (TIMEOUT != 0) && (state == ST_RUN) && (cycle_count == TO_M1);
    assign drain_idle = (pend_p1 == '0) && (fifo_cnt == '0) && (chg_p0 == '0);
    assign finished   = (state == ST_FIN);

    // Capture changed values; a channel stays pending if it changes while being pushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                shadow_p1[c] <= '0;
            end
            pend_p1 <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (chg_p0[c]) begin
                    shadow_p1[c] <= report[c*W +: W];
                end
            end
            pend_p1 <= chg_p0 | (pend_p1 & ~pop_ch);
        end
    end

    // FIFO storage; contents are qualified by fifo_cnt so they need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            chan_mem[wr_ptr] <= sel;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Saturating statistics: overwritten pending values and elapsed cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coalesced   <= 16'd0;
            cycle_count <= 32'd0;
        end else begin
            coalesced   <= sat_add16(coalesced, coal_inc);
            cycle_count <= sat_inc32(cycle_count);
        end
    end

    // Done hold filter: counts consecutive high cycles, clears on any low cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= 16'd0;
        end else if (!done) begin
            hold_cnt <= 16'd0;
        end else if (hold_cnt < HOLD_MAX) begin
            hold_cnt <= hold_cnt + 16'd1;
        end
    end

    // RUN -> DRAIN -> FINISHED; the watchdog takes precedence over a done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            succ_cap  <= 1'b0;
            timed_out <= 1'b0;
            passed    <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (wd_fire) begin
                        timed_out <= 1'b1;
                        succ_cap  <= 1'b0;
                        state     <= ST_DRAIN;
                    end else if (accept) begin
                        succ_cap <= success;
                        state    <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_idle) begin
                        passed <= succ_cap & ~timed_out;
                        state  <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    state <= ST_FIN;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    logic fin_d;

    // Simulation-only trace of log transfers, verdict line and end of run.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fin_d <= 1'b0;
        end else begin
            fin_d <= finished;
            if (log_valid && log_ready) begin
                $display("sim_finisher_mc: log ch%0d = 0x%h", log_chan, log_data);
            end
            if (finished && !fin_d) begin
                if (passed) begin
                    $display("sim_finisher_mc: end of simulation at cycle %0d, verdict PASS", cycle_count);
                end else begin
                    $display("sim_finisher_mc: end of simulation at cycle %0d, verdict no-pass (timed_out=%0d)",
                             cycle_count, timed_out);
                end
                if (FINISH_EN != 0) begin
                    $finish;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_sim_finisher_mc.sv
// Testbench for sim_finisher_mc: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the log path.
module tb_sim_finisher_mc;

    localparam int NCH   = 4;
    localparam int W     = 32;
    localparam int DEPTH = 8;

    logic             clk;
    logic             rst_n;
    logic [NCH*W-1:0] report;
    logic             success;
    logic             done;
    logic             log_ready;
    logic             log_valid;
    logic [3:0]       log_chan;
    logic [W-1:0]     log_data;
    logic [15:0]      coalesced;
    logic [31:0]      cycle_count;
    logic             finished;
    logic             passed;
    logic             timed_out;

    logic             rst_n_wd;
    logic [NCH*W-1:0] report_wd;
    logic             success_wd;
    logic             done_wd;
    logic             ready_wd;
    logic             wd_log_valid;
    logic [3:0]       wd_log_chan;
    logic [W-1:0]     wd_log_data;
    logic [15:0]      wd_coalesced;
    logic [31:0]      wd_cycle_count;
    logic             wd_finished;
    logic             wd_passed;
    logic             wd_timed_out;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0]   chan;
        logic [W-1:0] data;
    } ent_t;

    ent_t         mq[$];
    logic [W-1:0] m_val [NCH];
    bit           m_pend [NCH];
    int           m_coal;

    sim_finisher_mc #(.NCH(NCH), .W(W), .DEPTH(DEPTH), .DONE_HOLD(2), .TIMEOUT(0), .FINISH_EN(0)) dut (
        .clk(clk), .rst_n(rst_n), .report(report), .success(success), .done(done),
        .log_ready(log_ready), .log_valid(log_valid), .log_chan(log_chan), .log_data(log_data),
        .coalesced(coalesced), .cycle_count(cycle_count), .finished(finished), .passed(passed),
        .timed_out(timed_out)
    );

    sim_finisher_mc #(.NCH(NCH), .W(W), .DEPTH(DEPTH), .DONE_HOLD(2), .TIMEOUT(100), .FINISH_EN(0)) dut_wd (
        .clk(clk), .rst_n(rst_n_wd), .report(report_wd), .success(success_wd), .done(done_wd),
        .log_ready(ready_wd), .log_valid(wd_log_valid), .log_chan(wd_log_chan), .log_data(wd_log_data),
        .coalesced(wd_coalesced), .cycle_count(wd_cycle_count), .finished(wd_finished),
        .passed(wd_passed), .timed_out(wd_timed_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete in time");
        $fatal(1, "global timeout");
    end

    task automatic model_clear();
        mq.delete();
        for (int c = 0; c < NCH; c++) begin
            m_val[c]  = '0;
            m_pend[c] = 1'b0;
        end
        m_coal = 0;
    endtask

    // One clock of the log path: the FIFO accepts one entry from the lowest
    // waiting channel if it had room, a changed channel keeps only its newest
    // value, and the head leaves when the consumer was ready.
    task automatic model_step();
        int   pick;
        int   pre;
        ent_t e;
        pre  = mq.size();
        pick = -1;
        for (int c = 0; c < NCH; c++) begin
            if (pick < 0 && m_pend[c]) pick = c;
        end
        if (pick >= 0 && pre < DEPTH) begin
            e.chan = 4'(pick);
            e.data = m_val[pick];
            mq.push_back(e);
            m_pend[pick] = 1'b0;
        end
        for (int c = 0; c < NCH; c++) begin
            if (report[c*W +: W] !== m_val[c]) begin
                if (m_pend[c] && m_coal < 65535) m_coal++;
                m_val[c]  = report[c*W +: W];
                m_pend[c] = 1'b1;
            end
        end
        if (pre > 0 && log_ready) void'(mq.pop_front());
    endtask

    // Advance one clock; outputs are then observed at the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        report    = '0;
        done      = 1'b0;
        success   = 1'b0;
        log_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; report = '0; done = 1'b0; success = 1'b0; log_ready = 1'b1;
        model_clear();
        @(negedge clk);
        checks++;
        if ({log_valid, finished, passed, timed_out} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {log_valid, finished, passed, timed_out});
        end
        checks++;
        if (coalesced !== 16'd0 || cycle_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: got coal=%0d cyc=%0d expected 0/0", coalesced, cycle_count);
        end
        checks++;
        if (log_chan !== 4'd0 || log_data !== '0) begin
            errors++;
            $display("FAIL reset_log: got chan=%0d data=%h expected 0/0", log_chan, log_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle();
        checks++;
        if (cycle_count !== 32'd3) begin
            errors++;
            $display("FAIL cycle_count_start: got %0d expected 3", cycle_count);
        end
    endtask

    task automatic test_single_change();
        do_reset();
        log_ready = 1'b1;
        report[2*W +: W] = 32'hDEAD_BEEF;
        cycle();
        checks++;
        if (log_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_detect: got log_valid=%b expected 0", log_valid);
        end
        cycle();
        checks++;
        if (log_valid !== 1'b1 || log_chan !== 4'd2 || log_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_entry: got v=%b chan=%0d data=%h expected 1/2/deadbeef",
                     log_valid, log_chan, log_data);
        end
        repeat (4) cycle();
        checks++;
        if (log_valid !== 1'b0 || coalesced !== 16'd0) begin
            errors++;
            $display("FAIL single_once: got v=%b coal=%0d expected 0/0", log_valid, coalesced);
        end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] vals [NCH];
        do_reset();
        log_ready = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            vals[c] = $urandom | 32'h1;
            report[c*W +: W] = vals[c];
        end
        cycle();
        for (int k = 0; k < NCH; k++) begin
            cycle();
            checks++;
            if (log_valid !== 1'b1 || log_chan !== 4'(k) || log_data !== vals[k]) begin
                errors++;
                $display("FAIL simul_order_%0d: got v=%b chan=%0d data=%h expected 1/%0d/%h",
                         k, log_valid, log_chan, log_data, k, vals[k]);
            end
        end
        cycle();
        checks++;
        if (log_valid !== 1'b0 || coalesced !== 16'd0) begin
            errors++;
            $display("FAIL simul_end: got v=%b coal=%0d expected 0/0", log_valid, coalesced);
        end
    endtask

    task automatic test_back_pressure();
        ent_t got[$];
        do_reset();
        log_ready = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            report[1*W +: W] = 32'hA000_0000 + 32'(i);
            cycle();
        end
        repeat (3) begin
            cycle();
            checks++;
            if (log_valid !== 1'b1 || log_chan !== 4'd1 || log_data !== 32'hA000_0001) begin
                errors++;
                $display("FAIL bp_hold: got v=%b chan=%0d data=%h expected 1/1/a0000001",
                         log_valid, log_chan, log_data);
            end
        end
        checks++;
        if (coalesced !== 16'd3) begin
            errors++;
            $display("FAIL bp_coalesced: got %0d expected 3", coalesced);
        end
        log_ready = 1'b1;
        for (int k = 0; k < 40 && got.size() < 9; k++) begin
            if (log_valid) got.push_back({log_chan, log_data});
            cycle();
        end
        checks++;
        if (got.size() != 9) begin
            errors++;
            $display("FAIL bp_count: got %0d entries expected 9", got.size());
        end
        for (int k = 0; k < got.size(); k++) begin
            logic [W-1:0] exp_d;
            exp_d = (k < 8) ? 32'hA000_0000 + 32'(k + 1) : 32'hA000_000C;
            checks++;
            if (got[k].chan !== 4'd1 || got[k].data !== exp_d) begin
                errors++;
                $display("FAIL bp_entry_%0d: got chan=%0d data=%h expected 1/%h", k, got[k].chan, got[k].data, exp_d);
            end
        end
        repeat (3) cycle();
        checks++;
        if (log_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drained: got log_valid=%b expected 0", log_valid);
        end
    endtask

    task automatic test_done_filter();
        int n_xfer;
        do_reset();
        success = 1'b1;
        done    = 1'b1;
        cycle();
        done = 1'b0;
        repeat (6) cycle();
        checks++;
        if (finished !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got finished=%b expected 0", finished);
        end
        log_ready = 1'b0;
        for (int c = 0; c < 3; c++) report[c*W +: W] = 32'h5500_0000 + 32'(c);
        repeat (5) cycle();
        done = 1'b1; success = 1'b1;
        repeat (2) cycle();
        done = 1'b0; success = 1'b0;
        repeat (5) cycle();
        checks++;
        if (finished !== 1'b0 || log_valid !== 1'b1) begin
            errors++;
            $display("FAIL done_wait_drain: got finished=%b v=%b expected 0/1", finished, log_valid);
        end
        log_ready = 1'b1;
        n_xfer = 0;
        for (int k = 0; k < 20 && !finished; k++) begin
            if (log_valid) n_xfer++;
            cycle();
        end
        checks++;
        if (finished !== 1'b1 || n_xfer != 3) begin
            errors++;
            $display("FAIL done_drain: got finished=%b xfers=%0d expected 1/3", finished, n_xfer);
        end
        checks++;
        if (passed !== 1'b1 || timed_out !== 1'b0) begin
            errors++;
            $display("FAIL done_passed: got passed=%b timed_out=%b expected 1/0", passed, timed_out);
        end
        done = 1'b1;
        repeat (4) cycle();
        done = 1'b0;
        checks++;
        if (finished !== 1'b1 || passed !== 1'b1) begin
            errors++;
            $display("FAIL done_sticky: got finished=%b passed=%b expected 1/1", finished, passed);
        end
    endtask

    task automatic test_fail_verdict();
        do_reset();
        log_ready = 1'b1;
        success   = 1'b0;
        done      = 1'b1;
        repeat (2) cycle();
        done = 1'b0;
        checks++;
        if (finished !== 1'b0) begin
            errors++;
            $display("FAIL verdict_early: got finished=%b expected 0", finished);
        end
        cycle();
        checks++;
        if (finished !== 1'b1 || passed !== 1'b0 || timed_out !== 1'b0) begin
            errors++;
            $display("FAIL verdict_nopass: got fin=%b passed=%b to=%b expected 1/0/0", finished, passed, timed_out);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        log_ready = 1'b0;
        for (int c = 0; c < NCH; c++) report[c*W +: W] = 32'h7700_0000 + 32'(c);
        cycle();
        report[0 +: W] = 32'h7700_0010;
        repeat (6) cycle();
        done = 1'b1; success = 1'b1;
        repeat (2) cycle();
        done = 1'b0;
        repeat (2) cycle();
        checks++;
        if (log_valid !== 1'b1 || finished !== 1'b0) begin
            errors++;
            $display("FAIL middrain_pre: got v=%b fin=%b expected 1/0", log_valid, finished);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (log_valid !== 1'b0 || finished !== 1'b0 || coalesced !== 16'd0 || cycle_count !== 32'd0) begin
            errors++;
            $display("FAIL middrain_reset: got v=%b fin=%b coal=%0d cyc=%0d expected all 0",
                     log_valid, finished, coalesced, cycle_count);
        end
        report = '0; done = 1'b0; success = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n     = 1'b1;
        log_ready = 1'b1;
        report[3*W +: W] = 32'h1234_5678;
        repeat (2) cycle();
        checks++;
        if (log_valid !== 1'b1 || log_chan !== 4'd3 || log_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL middrain_fresh_log: got v=%b chan=%0d data=%h expected 1/3/12345678",
                     log_valid, log_chan, log_data);
        end
        done = 1'b1; success = 1'b1;
        repeat (2) cycle();
        done = 1'b0;
        for (int k = 0; k < 10 && !finished; k++) cycle();
        checks++;
        if (finished !== 1'b1 || passed !== 1'b1) begin
            errors++;
            $display("FAIL middrain_fresh_end: got fin=%b passed=%b expected 1/1", finished, passed);
        end
    endtask

    task automatic test_random_traffic();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            log_ready = (i < 200) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) != 0);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 3) == 0) report[c*W +: W] = 32'($urandom_range(0, 3));
            end
            cycle();
            checks++;
            if (log_valid !== (mq.size() > 0)) begin
                errors++;
                $display("FAIL rand_valid@%0d: got %b expected %b", i, log_valid, mq.size() > 0);
            end
            if (mq.size() > 0) begin
                checks++;
                if (log_chan !== mq[0].chan || log_data !== mq[0].data) begin
                    errors++;
                    $display("FAIL rand_entry@%0d: got chan=%0d data=%h expected %0d/%h",
                             i, log_chan, log_data, mq[0].chan, mq[0].data);
                end
            end
            checks++;
            if (coalesced !== 16'(m_coal)) begin
                errors++;
                $display("FAIL rand_coalesced@%0d: got %0d expected %0d", i, coalesced, m_coal);
            end
        end
        log_ready = 1'b1;
        repeat (40) cycle();
        checks++;
        if (log_valid !== 1'b0 || coalesced !== 16'(m_coal)) begin
            errors++;
            $display("FAIL rand_flush: got v=%b coal=%0d expected 0/%0d", log_valid, coalesced, m_coal);
        end
    endtask

    task automatic test_watchdog();
        int n;
        n = 0;
        @(negedge clk);
        rst_n_wd = 1'b1;
        for (int k = 1; k <= 150; k++) begin
            cycle();
            if (wd_timed_out) begin
                n = k;
                break;
            end
        end
        checks++;
        if (n != 100 || wd_cycle_count !== 32'd100) begin
            errors++;
            $display("FAIL wd_fire: got at cycle %0d count=%0d expected 100/100", n, wd_cycle_count);
        end
        checks++;
        if (wd_finished !== 1'b0) begin
            errors++;
            $display("FAIL wd_drain: got finished=%b expected 0", wd_finished);
        end
        cycle();
        checks++;
        if (wd_finished !== 1'b1 || wd_passed !== 1'b0 || wd_timed_out !== 1'b1) begin
            errors++;
            $display("FAIL wd_end: got fin=%b passed=%b to=%b expected 1/0/1", wd_finished, wd_passed, wd_timed_out);
        end
    endtask

    initial begin
        rst_n_wd   = 1'b0;
        report_wd  = '0;
        success_wd = 1'b1;
        done_wd    = 1'b0;
        ready_wd   = 1'b1;
        rst_n      = 1'b0;
        report     = '0;
        done       = 1'b0;
        success    = 1'b0;
        log_ready  = 1'b0;
        test_reset();
        test_single_change();
        test_simultaneous();
        test_back_pressure();
        test_done_filter();
        test_fail_verdict();
        test_reset_mid_drain();
        test_random_traffic();
        test_watchdog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
